snn_ts_scheduler: RTL and testbench

Clocked timestep/layer sequencer for the SNN output-feature-map stage. It replaces the free-running start/ts/layer/done token sequence with an explicit state machine. The block issues one (timestep, layer) configuration beat per pass, then accepts and counts the DEPTH_R×DEPTH_R spike beats the ofmap stage returns. It reports the spike total per pass and pulses `done` after the final layer.

---
 rtl/snn_ts_scheduler.sv | 149 ++++++++++++++
 tb/tb_snn_ts_scheduler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_ts_scheduler.sv
// Timestep/layer sequencer for the SNN ofmap stage: issues one config beat per pass,
// counts the DEPTH_R*DEPTH_R returned spike beats, and reports per-pass totals.
module snn_ts_scheduler #(
    parameter int NUM_TS     = 2,
    parameter int NUM_LAYERS = 1,
    parameter int DEPTH_R    = 21,
    parameter int ADDR_W     = 9,
    parameter int CNT_W      = 9,
    parameter int TS_W       = 2,
    parameter int LAYER_W    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               cfg_valid,
    input  logic               cfg_ready,
    output logic [TS_W-1:0]    cfg_ts,
    output logic [LAYER_W-1:0] cfg_layer,
    input  logic               spk_valid,
    output logic               spk_ready,
    input  logic [ADDR_W-1:0]  spk_addr,
    input  logic               spk_data,
    output logic [CNT_W-1:0]   spk_count,
    output logic               cnt_valid,
    output logic               done,
    output logic               err,
    output logic [2:0]         dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // cfg_* is held stable while cfg_valid waits for cfg_ready.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CFG  = 3'd1,
        S_RUN  = 3'd2,
        S_NEXT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(DEPTH_R * DEPTH_R - 1);

    state_t             state_q, state_d;
    logic [TS_W-1:0]    ts_q, ts_d;
    logic [LAYER_W-1:0] layer_q, layer_d;
    logic [CNT_W-1:0]   beat_q, beat_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   spk_count_d;
    logic               err_d;
    logic               beat_acc;

    assign beat_acc  = spk_valid & spk_ready;
    assign cfg_ts    = ts_q;
    assign cfg_layer = layer_q;

    always_comb begin
        state_d     = state_q;
        ts_d        = ts_q;
        layer_d     = layer_q;
        beat_d      = beat_q;
        cnt_d       = cnt_q;
        spk_count_d = spk_count;
        err_d       = err;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ts_d    = TS_W'(1);
                    layer_d = LAYER_W'(1);
                    err_d   = 1'b0;
                    state_d = S_CFG;
                end
            end
            S_CFG: begin
                if (cfg_valid && cfg_ready) begin
                    beat_d  = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (beat_acc) begin
                    if (spk_addr != ADDR_W'(beat_q)) begin
                        err_d = 1'b1;
                    end
                    cnt_d = cnt_q + CNT_W'(spk_data);
                    if (beat_q == LAST_BEAT) begin
                        // Final beat's spike is folded into the reported total.
                        spk_count_d = cnt_d;
                        state_d     = S_NEXT;
                    end else begin
                        beat_d = beat_q + CNT_W'(1);
                    end
                end
            end
            S_NEXT: begin
                if (ts_q < TS_W'(NUM_TS)) begin
                    ts_d    = ts_q + TS_W'(1);
                    state_d = S_CFG;
                end else if (layer_q < LAYER_W'(NUM_LAYERS)) begin
                    layer_d = layer_q + LAYER_W'(1);
                    ts_d    = TS_W'(1);
                    state_d = S_CFG;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output flags are decoded from the next state so every output comes from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ts_q      <= '0;
            layer_q   <= '0;
            beat_q    <= '0;
            cnt_q     <= '0;
            spk_count <= '0;
            err       <= 1'b0;
            cfg_valid <= 1'b0;
            spk_ready <= 1'b0;
            busy      <= 1'b0;
            cnt_valid <= 1'b0;
            done      <= 1'b0;
            dbg_state <= 3'd0;
        end else begin
            state_q   <= state_d;
            ts_q      <= ts_d;
            layer_q   <= layer_d;
            beat_q    <= beat_d;
            cnt_q     <= cnt_d;
            spk_count <= spk_count_d;
            err       <= err_d;
            cfg_valid <= (state_d == S_CFG);
            spk_ready <= (state_d == S_RUN);
            busy      <= (state_d == S_CFG) || (state_d == S_RUN) || (state_d == S_NEXT);
            cnt_valid <= (state_d == S_NEXT);
            done      <= (state_d == S_DONE);
            dbg_state <= state_d;
        end
    end

endmodule

// File: tb/tb_snn_ts_scheduler.sv
// Scoreboard bench for snn_ts_scheduler: one instance per layer count, selected by sel,
// directed passes with hand-computed spike totals and config sequences.
module tb_snn_ts_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, cfg_ready, spk_valid, spk_data;
    logic [8:0] spk_addr;
    int         sel;

    // Per-instance wires
    logic       a_start, a_cfg_ready, a_spk_valid;
    logic       a_busy, a_cfg_valid, a_spk_ready, a_cnt_valid, a_done, a_err;
    logic [1:0] a_cfg_ts, a_cfg_layer;
    logic [8:0] a_spk_count;
    logic [2:0] a_dbg;
    logic       b_start, b_cfg_ready, b_spk_valid;
    logic       b_busy, b_cfg_valid, b_spk_ready, b_cnt_valid, b_done, b_err;
    logic [1:0] b_cfg_ts, b_cfg_layer;
    logic [8:0] b_spk_count;
    logic [2:0] b_dbg;

    // Selected-instance view
    logic       busy, cfg_valid, spk_ready, cnt_valid, done, err;
    logic [1:0] cfg_ts, cfg_layer;
    logic [8:0] spk_count;
    logic [2:0] dbg;

    int         n_err = 0;
    int         n_checks = 0;
    bit         abort = 1'b0;
    logic [3:0] exp_cfg_q[$];
    logic [8:0] exp_cnt_q[$];
    logic       exp_err_q[$];

    always #5 clk = ~clk;

    assign a_start     = start && (sel == 0);
    assign a_cfg_ready = cfg_ready && (sel == 0);
    assign a_spk_valid = spk_valid && (sel == 0);
    assign b_start     = start && (sel == 1);
    assign b_cfg_ready = cfg_ready && (sel == 1);
    assign b_spk_valid = spk_valid && (sel == 1);

    assign busy      = (sel == 1) ? b_busy      : a_busy;
    assign cfg_valid = (sel == 1) ? b_cfg_valid : a_cfg_valid;
    assign spk_ready = (sel == 1) ? b_spk_ready : a_spk_ready;
    assign cnt_valid = (sel == 1) ? b_cnt_valid : a_cnt_valid;
    assign done      = (sel == 1) ? b_done      : a_done;
    assign err       = (sel == 1) ? b_err       : a_err;
    assign cfg_ts    = (sel == 1) ? b_cfg_ts    : a_cfg_ts;
    assign cfg_layer = (sel == 1) ? b_cfg_layer : a_cfg_layer;
    assign spk_count = (sel == 1) ? b_spk_count : a_spk_count;
    assign dbg       = (sel == 1) ? b_dbg       : a_dbg;

    snn_ts_scheduler #(.NUM_TS(2), .NUM_LAYERS(1)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .busy(a_busy),
        .cfg_valid(a_cfg_valid), .cfg_ready(a_cfg_ready),
        .cfg_ts(a_cfg_ts), .cfg_layer(a_cfg_layer),
        .spk_valid(a_spk_valid), .spk_ready(a_spk_ready),
        .spk_addr(spk_addr), .spk_data(spk_data),
        .spk_count(a_spk_count), .cnt_valid(a_cnt_valid),
        .done(a_done), .err(a_err), .dbg_state(a_dbg)
    );

    snn_ts_scheduler #(.NUM_TS(2), .NUM_LAYERS(2)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy),
        .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready),
        .cfg_ts(b_cfg_ts), .cfg_layer(b_cfg_layer),
        .spk_valid(b_spk_valid), .spk_ready(b_spk_ready),
        .spk_addr(spk_addr), .spk_data(spk_data),
        .spk_count(b_spk_count), .cnt_valid(b_cnt_valid),
        .done(b_done), .err(b_err), .dbg_state(b_dbg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_checks++;
        n_err++;
        $display("FAIL %s: got %0d with nothing expected at %0t", name, act, $time);
    endtask

    // Monitor: pops the scoreboard on every completed output event.
    always @(negedge clk) begin
        if (!rst) begin
            if (cfg_valid && cfg_ready) begin
                if (exp_cfg_q.size() == 0) fail_now("cfg_unexpected", {28'd0, cfg_ts, cfg_layer});
                else check("cfg_beat", {28'd0, cfg_ts, cfg_layer}, {28'd0, exp_cfg_q.pop_front()});
            end
            if (cnt_valid) begin
                if (exp_cnt_q.size() == 0) fail_now("cnt_unexpected", {23'd0, spk_count});
                else check("spk_count", {23'd0, spk_count}, {23'd0, exp_cnt_q.pop_front()});
                check("ready_in_next", {31'd0, spk_ready}, 32'd0);
            end
            if (done) begin
                if (exp_err_q.size() == 0) fail_now("done_unexpected", {31'd0, err});
                else check("err_at_done", {31'd0, err}, {31'd0, exp_err_q.pop_front()});
                check("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    function automatic logic spk_bit(input int mode, input int i);
        case (mode)
            1:       return (i < 10);
            2:       return 1'b1;
            3:       return (i % 3 == 0);
            default: return 1'b0;
        endcase
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Streams n beats; bad_idx gets a wrong address, start_at pulses start mid-run.
    task automatic stream(input int mode, input int n, input int bad_idx,
                          input bit bubbles, input int start_at);
        bit acc;
        if (abort) return;
        for (int i = 0; i < n; i++) begin
            if (bubbles && $urandom_range(0, 2) == 0) begin
                spk_valid = 1'b0;
                @(posedge clk); #1;
            end
            spk_valid = 1'b1;
            spk_addr  = (i == bad_idx) ? 9'(i + 1) : 9'(i);
            spk_data  = spk_bit(mode, i);
            if (i == start_at) start = 1'b1;
            acc = 1'b0;
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                acc = spk_ready;
                @(posedge clk); #1;
                start = 1'b0;
                if (acc) break;
            end
            if (!acc) begin
                fail_now("beat_timeout", i);
                abort = 1'b1;
                spk_valid = 1'b0;
                return;
            end
            if (i == bad_idx) check("err_after_bad", {31'd0, err}, 32'd1);
        end
        spk_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_now("done_timeout", 0);
        @(posedge clk); #1;
        check("cfg_q_empty", exp_cfg_q.size(), 0);
        check("cnt_q_empty", exp_cnt_q.size(), 0);
        check("err_q_empty", exp_err_q.size(), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_ready = 1'b0; spk_valid = 1'b0;
        spk_data = 1'b0; spk_addr = '0; sel = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs_a", {a_busy, a_cfg_valid, a_cfg_ts, a_cfg_layer, a_spk_ready,
              a_spk_count, a_cnt_valid, a_done, a_err, a_dbg}, 32'd0);
        rst = 1'b0;

        // Nominal run: 10 spikes then none; NEXT-cycle beat left pending
        cfg_ready = 1'b1;
        exp_cfg_q.push_back(4'h5); exp_cfg_q.push_back(4'h9);
        exp_cnt_q.push_back(9'd10); exp_cnt_q.push_back(9'd0);
        exp_err_q.push_back(1'b0);
        pulse_start();
        check("start_cfg_valid", {31'd0, cfg_valid}, 32'd1);
        check("start_busy", {31'd0, busy}, 32'd1);
        stream(1, 441, -1, 1'b0, -1);
        stream(0, 441, -1, 1'b0, -1);
        wait_done();
        check("nominal_err", {31'd0, err}, 32'd0);

        // Config backpressure, then bubbly all-spike pass with an ignored start
        cfg_ready = 1'b0;
        exp_cfg_q.push_back(4'h5); exp_cfg_q.push_back(4'h9);
        exp_cnt_q.push_back(9'd441); exp_cnt_q.push_back(9'd147);
        exp_err_q.push_back(1'b0);
        pulse_start();
        for (int k = 0; k < 5; k++) begin
            check("bp_cfg_valid", {31'd0, cfg_valid}, 32'd1);
            check("bp_cfg_fields", {28'd0, cfg_ts, cfg_layer}, 32'h5);
            check("bp_spk_ready", {31'd0, spk_ready}, 32'd0);
            @(posedge clk); #1;
        end
        cfg_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_run_next", {31'd0, spk_ready}, 32'd1);
        stream(2, 441, -1, 1'b1, 200);
        stream(3, 441, -1, 1'b1, -1);
        wait_done();

        // Address error at beat 7; count stays correct, err sticky through done
        exp_cfg_q.push_back(4'h5); exp_cfg_q.push_back(4'h9);
        exp_cnt_q.push_back(9'd10); exp_cnt_q.push_back(9'd0);
        exp_err_q.push_back(1'b1);
        pulse_start();
        stream(1, 441, 7, 1'b0, -1);
        stream(0, 441, -1, 1'b0, -1);
        wait_done();
        check("err_sticky_idle", {31'd0, err}, 32'd1);

        // Start clears err; reset after 100 beats, then recovery from (1,1)
        exp_cfg_q.push_back(4'h5);
        pulse_start();
        check("err_cleared", {31'd0, err}, 32'd0);
        stream(1, 100, -1, 1'b0, -1);
        #2 rst = 1'b1;
        #1;
        check("midrun_reset_a", {a_busy, a_cfg_valid, a_cfg_ts, a_cfg_layer, a_spk_ready,
              a_spk_count, a_cnt_valid, a_done, a_err, a_dbg}, 32'd0);
        check("reset_cfg_q_drained", exp_cfg_q.size(), 0);
        exp_cfg_q.delete(); exp_cnt_q.delete(); exp_err_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_cfg_q.push_back(4'h5); exp_cfg_q.push_back(4'h9);
        exp_cnt_q.push_back(9'd10); exp_cnt_q.push_back(9'd0);
        exp_err_q.push_back(1'b0);
        pulse_start();
        check("recover_cfg", {27'd0, cfg_valid, cfg_ts, cfg_layer}, 32'h15);
        stream(1, 441, -1, 1'b0, -1);
        stream(0, 441, -1, 1'b0, -1);
        wait_done();

        // Two layers on the second instance
        sel = 1;
        exp_cfg_q.push_back(4'h5); exp_cfg_q.push_back(4'h9);
        exp_cfg_q.push_back(4'h6); exp_cfg_q.push_back(4'hA);
        exp_cnt_q.push_back(9'd10); exp_cnt_q.push_back(9'd0);
        exp_cnt_q.push_back(9'd441); exp_cnt_q.push_back(9'd147);
        exp_err_q.push_back(1'b0);
        pulse_start();
        stream(1, 441, -1, 1'b0, -1);
        stream(0, 441, -1, 1'b0, -1);
        stream(2, 441, -1, 1'b1, -1);
        stream(3, 441, -1, 1'b0, -1);
        wait_done();
        check("ml_idle_state", {29'd0, dbg}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
